// File: rtl/rf_write_queue_if.sv
// rtl/rf_write_queue_if.sv - handshake/bus bundle between the pipeline and the write-back queue
// Signals:
//   wb_valid/wb_ready/wb_reg/wb_data         write request handshake from the pipeline
//   rf_hold                                   register file busy, suppresses issue
//   rf_decoder_control/rf_load_enable/
//   rf_write_data                             registered write issued to decoder and bank
//   query_reg_a/query_reg_b, pending_a/b      hazard query and combinational answers
//   count                                     current queue occupancy
// Modports: master = pipeline side, slave = queue side.
interface rf_write_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [3:0]            wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rf_hold;
  logic [3:0]            rf_decoder_control;
  logic                  rf_load_enable;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic [3:0]            query_reg_a;
  logic [3:0]            query_reg_b;
  logic                  pending_a;
  logic                  pending_b;
  logic [CW-1:0]         count;

  modport master (
    output wb_valid, wb_reg, wb_data, rf_hold, query_reg_a, query_reg_b,
    input  wb_ready, rf_decoder_control, rf_load_enable, rf_write_data,
           pending_a, pending_b, count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, rf_hold, query_reg_a, query_reg_b,
    output wb_ready, rf_decoder_control, rf_load_enable, rf_write_data,
           pending_a, pending_b, count
  );
endinterface

// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - in-order register-file write-back queue with hazard query
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high, clears pointers, count and issue registers
//   bus    rf_write_queue_if.slave: write request in, registered write out,
//          hazard query in, pending flags and occupancy out
module rf_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic             clk,
  input logic             reset,
  rf_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]            r_mem_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [3:0]            r_dec;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_hit_a;
  logic w_hit_b;

  // Full/empty come from the occupancy counter; pointers alone are ambiguous.
  assign w_ready = (r_count != CW'(DEPTH));
  assign w_push  = bus.wb_valid && w_ready;
  assign w_pop   = (r_count != '0) && !bus.rf_hold;

  // Storage needs no reset: only entries inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_tail]  <= bus.wb_reg;
      r_mem_data[r_tail] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_dec   <= '0;
      r_en    <= 1'b0;
      r_wdata <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      // Decoder control and data hold their last value when nothing issues.
      if (w_pop) begin
        r_head  <= r_head + PW'(1);
        r_dec   <= r_mem_reg[r_head];
        r_wdata <= r_mem_data[r_head];
        r_en    <= 1'b1;
      end else begin
        r_en    <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Hazard flags cover the live FIFO window plus the write on the outputs.
  // A request being pushed this cycle is deliberately not included.
  always_comb begin
    w_hit_a = r_en && (r_dec == bus.query_reg_a);
    w_hit_b = r_en && (r_dec == bus.query_reg_b);
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if (r_mem_reg[r_head + PW'(i)] == bus.query_reg_a) w_hit_a = 1'b1;
        if (r_mem_reg[r_head + PW'(i)] == bus.query_reg_b) w_hit_b = 1'b1;
      end
    end
  end

  assign bus.wb_ready           = w_ready;
  assign bus.rf_decoder_control = r_dec;
  assign bus.rf_load_enable     = r_en;
  assign bus.rf_write_data      = r_wdata;
  assign bus.pending_a          = w_hit_a;
  assign bus.pending_b          = w_hit_b;
  assign bus.count              = r_count;
endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - scoreboard bench for rf_write_queue
module tb_rf_write_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  rf_write_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits for space, records the expectation, and lets the edge accept it.
  task automatic push(input logic [3:0] r, input logic [31:0] d);
    int n = 0;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = r;
    bus.wb_data  = d;
    while (!bus.wb_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", bus.wb_ready, 1);
    exp_q.push_back({r, d});
    tick();
  endtask

  task automatic drain();
    int n = 0;
    bus.wb_valid = 1'b0;
    bus.rf_hold  = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    tick();
  endtask

  // Monitor: every issued write must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.rf_load_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got reg %0d data %h, required no issue",
                 bus.rf_decoder_control, bus.rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_reg", bus.rf_decoder_control, mon_e.r);
        chk("issue_data", bus.rf_write_data, mon_e.d);
      end
    end
  end

  initial begin
    int acc;
    int c;
    bus.wb_valid    = 1'b0;
    bus.wb_reg      = '0;
    bus.wb_data     = '0;
    bus.rf_hold     = 1'b0;
    bus.query_reg_a = '0;
    bus.query_reg_b = '0;

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_en", bus.rf_load_enable, 0);
    chk("rst_ctrl", bus.rf_decoder_control, 0);
    chk("rst_data", bus.rf_write_data, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ready", bus.wb_ready, 1);
    chk("rst_pend_a", bus.pending_a, 0);

    // Single write: accepted at edge 1, issued after edge 2, gone after edge 3.
    push(4'd5, 32'hDEADBEEF);
    bus.wb_valid = 1'b0;
    chk("single_count1", bus.count, 1);
    chk("single_en_early", bus.rf_load_enable, 0);
    tick();
    chk("single_en", bus.rf_load_enable, 1);
    chk("single_ctrl", bus.rf_decoder_control, 5);
    chk("single_data", bus.rf_write_data, 32'hDEADBEEF);
    chk("single_count0", bus.count, 0);
    tick();
    chk("single_en_off", bus.rf_load_enable, 0);

    // Fill under hold, fifth request refused, then four back-to-back issues.
    bus.rf_hold = 1'b1;
    push(4'd1, 32'h0000_0101);
    push(4'd2, 32'h0000_0202);
    push(4'd3, 32'h0000_0303);
    push(4'd4, 32'h0000_0404);
    bus.wb_reg  = 4'd5;
    bus.wb_data = 32'h0000_0505;
    chk("full_count", bus.count, 4);
    chk("full_ready", bus.wb_ready, 0);
    repeat (2) tick();
    chk("full_count_hold", bus.count, 4);
    bus.wb_valid = 1'b0;
    bus.rf_hold  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_en", bus.rf_load_enable, 1);
    end
    tick();
    chk("burst_en_off", bus.rf_load_enable, 0);
    chk("burst_count", bus.count, 0);

    // Wrap-around: ten requests with hold toggling every cycle.
    acc = 0;
    c   = 0;
    while (acc < 10 && c < 200) begin
      bus.rf_hold  = c[0];
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 4'(acc + 6);
      bus.wb_data  = 32'hA000_0000 + 32'(acc);
      if (bus.wb_ready) begin
        exp_q.push_back({4'(acc + 6), 32'hA000_0000 + 32'(acc)});
        acc++;
      end
      tick();
      chk("wrap_count_max", bus.count <= 3'd4, 1);
      c++;
    end
    chk("wrap_accepted", acc, 10);
    drain();

    // Hazard query against queued and issuing writes.
    bus.rf_hold = 1'b1;
    push(4'd7, 32'h0000_0007);
    push(4'd9, 32'h0000_0009);
    bus.wb_valid    = 1'b0;
    bus.query_reg_a = 4'd9;
    bus.query_reg_b = 4'd3;
    #1;
    chk("haz_a_queued", bus.pending_a, 1);
    chk("haz_b_queued", bus.pending_b, 0);
    bus.rf_hold = 1'b0;
    tick();
    chk("haz_a_issue7", bus.pending_a, 1);
    tick();
    chk("haz_a_issue9", bus.pending_a, 1);
    chk("haz_b_issue9", bus.pending_b, 0);
    tick();
    chk("haz_a_done", bus.pending_a, 0);

    // Duplicate destination: both writes issue, in order.
    push(4'd2, 32'h0000_0011);
    push(4'd2, 32'h0000_0022);
    drain();

    // Reset while three entries are queued and one is on the outputs.
    bus.rf_hold = 1'b1;
    push(4'd10, 32'h0000_000A);
    push(4'd11, 32'h0000_000B);
    push(4'd12, 32'h0000_000C);
    push(4'd13, 32'h0000_000D);
    bus.wb_valid    = 1'b0;
    bus.rf_hold     = 1'b0;
    bus.query_reg_a = 4'd11;
    bus.query_reg_b = 4'd12;
    tick();
    chk("prerst_en", bus.rf_load_enable, 1);
    chk("prerst_count", bus.count, 3);
    bus.rf_hold = 1'b1;
    reset       = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    chk("midrst_en", bus.rf_load_enable, 0);
    chk("midrst_ctrl", bus.rf_decoder_control, 0);
    chk("midrst_data", bus.rf_write_data, 0);
    chk("midrst_count", bus.count, 0);
    chk("midrst_ready", bus.wb_ready, 1);
    chk("midrst_pend_a", bus.pending_a, 0);
    chk("midrst_pend_b", bus.pending_b, 0);
    bus.rf_hold = 1'b0;
    push(4'd3, 32'h0000_0033);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
